cam_pwr_seq: RTL and testbench
==============================

Name: cam_pwr_seq

Overview:
- Sits directly downstream of the clock wizard. Consumes its `locked` status and runs in the 25 MHz `clk_out1` domain.
- Sequences CMOS sensor power-up and releases the downstream system reset:
  - PWDN, then RESET_N, then a settle wait.
  - Starts SCCB configuration and waits for it to complete.
- Asserts `ready` only once clocks are stable and the sensor is configured. Re-runs the whole sequence if lock is lost.

Parameters:
- LOCK_STABLE_CYC, 1024, consecutive synced-locked cycles required before sequencing starts
- PWDN_CYC, 125000, cycles `cmos_pwdn` is held high after lock is stable (5 ms at 25 MHz)
- RST_CYC, 25000, cycles `cmos_rst_n` is held low after PWDN deasserts (1 ms)
- SETTLE_CYC, 500000, cycles after RESET_N release before configuration starts (20 ms)
- CFG_TIMEOUT_CYC, 2500000, maximum cycles to wait for `cfg_done` (100 ms)
- CNT_W, 24, timer width; must satisfy 2^CNT_W > max of all cycle parameters

Ports:
- clk  input  1  system clock (`clk_out1` from clock wizard)
- reset  input  1  synchronous, active-high reset
- locked  input  1  clock wizard lock, asynchronous to `clk`
- cfg_done  input  1  level from SCCB config block, high when configuration is complete
- cmos_pwdn  output  1  sensor power-down, active high
- cmos_rst_n  output  1  sensor reset, active low
- sys_rst_n  output  1  downstream datapath reset, active low
- cfg_start  output  1  single-cycle pulse to start SCCB configuration
- ready  output  1  sequence complete
- retry_cnt  output  4  number of configuration timeouts, saturating
- state  output  3  current state encoding, for debug

Behaviour:
- One clock domain. `reset` is synchronous and active-high: sampled on the rising edge of `clk` only.
- `locked` passes through a 2-flop synchroniser to give `lock_s`. Synchroniser flops reset to 0.
- Reset values of outputs:
  - cmos_pwdn = 1, cmos_rst_n = 0, sys_rst_n = 0
  - cfg_start = 0, ready = 0
  - retry_cnt = 0, state = S_WAIT_LOCK (0)
- All outputs are registered and change on the same edge as the state register.
- One shared timer `tmr` [CNT_W-1:0]:
  - cleared on every state entry
  - increments while in a timed state
  - a state of length N exits on the edge where tmr == N-1, so the state occupies exactly N cycles
- S_WAIT_LOCK (0):
  - outputs held at their reset values
  - tmr counts while lock_s = 1 and clears while lock_s = 0
  - at tmr == LOCK_STABLE_CYC-1 with lock_s = 1, go to S_PWDN
- S_PWDN (1): pwdn = 1, rst_n = 0. After PWDN_CYC cycles, go to S_RST.
- S_RST (2): pwdn = 0, rst_n = 0. After RST_CYC cycles, go to S_SETTLE.
- S_SETTLE (3): pwdn = 0, rst_n = 1. After SETTLE_CYC cycles, go to S_CFG.
- S_CFG (4):
  - sys_rst_n = 1; cfg_start = 1 in the first cycle of the state only
  - if cfg_done = 1 is sampled from the second cycle onward, go to S_READY. cfg_done in the pulse cycle is ignored.
  - if tmr == CFG_TIMEOUT_CYC-1 without cfg_done: retry_cnt increments (saturating at 15), sys_rst_n returns to 0, go to S_PWDN
  - if cfg_done and timeout occur in the same cycle, cfg_done wins
- S_READY (5): ready = 1, sys_rst_n = 1, pwdn = 0, rst_n = 1. Stays here while lock_s = 1.
- Lock loss:
  - lock_s = 0 in any state other than S_WAIT_LOCK causes a transition to S_WAIT_LOCK on the next edge
  - outputs return to their reset values, except retry_cnt, which is retained
  - lock loss has priority over every other transition
- `reset` asserted mid-sequence returns every register to its reset value on the next edge, including retry_cnt and the synchroniser.
- Encodings 6 and 7 are illegal and recover to S_WAIT_LOCK.

Decomposition:
- Package `cam_pwr_seq_pkg` holds:
  - state encoding localparams S_WAIT_LOCK .. S_READY (3-bit)
  - RETRY_MAX = 15
- Sub-module `sync_2ff` is the single-bit 2-flop synchroniser with synchronous active-high reset. It is reusable for other async status inputs.

Test Plan:
- Bench parameters for all scenarios: LOCK_STABLE_CYC = 8, PWDN_CYC = 4, RST_CYC = 4, SETTLE_CYC = 6, CFG_TIMEOUT_CYC = 20.
- Nominal sequence: hold reset, release, raise locked → cmos_pwdn falls 2 + 8 + 4 cycles after locked rises. Then rst_n rises 4 cycles later. Then one cfg_start pulse 6 cycles later. Drive cfg_done 3 cycles after the pulse → ready = 1 on the next edge, retry_cnt = 0.
- Glitchy lock: locked high for 5 cycles, low for 1, then high → no exit from S_WAIT_LOCK until 8 consecutive synced-high cycles after the glitch.
- Config timeout: never drive cfg_done → after 20 cycles in S_CFG, state returns to 1, sys_rst_n = 0, retry_cnt = 1. Repeat 17 times → retry_cnt saturates at 15.
- Lock loss in S_READY: drop locked → 3 edges later (2 sync + 1), state = 0, cmos_pwdn = 1, cmos_rst_n = 0, sys_rst_n = 0, ready = 0, retry_cnt retained.
- Simultaneous events: cfg_done rises in the same cycle tmr == 19 in S_CFG → goes to S_READY, retry_cnt unchanged.
- Reset mid-sequence: assert reset during S_SETTLE → next edge gives all outputs at reset values and state = 0. After release, the full sequence restarts from the lock-stable count.

Source files
------------

// File: rtl/cam_pwr_seq_pkg.sv
// Shared state encoding and limits for the camera power sequencer.
package cam_pwr_seq_pkg;
  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_PWDN      = 3'd1,
    S_RST       = 3'd2,
    S_SETTLE    = 3'd3,
    S_CFG       = 3'd4,
    S_READY     = 3'd5
  } state_e;

  localparam logic [3:0] RETRY_MAX = 4'd15;
endpackage

// File: rtl/cam_pwr_seq_sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous status inputs.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_d, meta_q, sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/cam_pwr_seq.sv
// CMOS sensor power-up sequencer: waits for stable clock lock, walks PWDN,
// RESET_N and settle phases, starts SCCB config and releases system reset.
module cam_pwr_seq
  import cam_pwr_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int PWDN_CYC        = 125000,
  parameter int RST_CYC         = 25000,
  parameter int SETTLE_CYC      = 500000,
  parameter int CFG_TIMEOUT_CYC = 2500000,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  input  logic       cfg_done,
  output logic       cmos_pwdn,
  output logic       cmos_rst_n,
  output logic       sys_rst_n,
  output logic       cfg_start,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);
  logic             lock_s;
  state_e           state_d, state_q;
  logic [CNT_W-1:0] tmr_d, tmr_q;
  logic [3:0]       retry_d, retry_q;
  logic             pwdn_d, pwdn_q, rst_n_d, rst_n_q, sys_rst_n_d, sys_rst_n_q;
  logic             cfg_start_d, cfg_start_q, ready_d, ready_q;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (locked),
    .q     (lock_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      S_WAIT_LOCK: if (lock_s && tmr_q == CNT_W'(LOCK_STABLE_CYC - 1)) state_d = S_PWDN;
      S_PWDN:      if (tmr_q == CNT_W'(PWDN_CYC - 1))   state_d = S_RST;
      S_RST:       if (tmr_q == CNT_W'(RST_CYC - 1))    state_d = S_SETTLE;
      S_SETTLE:    if (tmr_q == CNT_W'(SETTLE_CYC - 1)) state_d = S_CFG;
      S_CFG: begin
        // cfg_done sampled in the pulse cycle is stale from a previous attempt
        if (cfg_done && !cfg_start_q) begin
          state_d = S_READY;
        end else if (tmr_q == CNT_W'(CFG_TIMEOUT_CYC - 1)) begin
          state_d = S_PWDN;
          if (retry_q != RETRY_MAX) retry_d = retry_q + 4'd1;
        end
      end
      S_READY:     state_d = S_READY;
      default:     state_d = S_WAIT_LOCK;
    endcase
    if (!lock_s) begin
      state_d = S_WAIT_LOCK;
      retry_d = retry_q;
    end

    if (state_d != state_q)
      tmr_d = '0;
    else if (state_q == S_WAIT_LOCK)
      tmr_d = lock_s ? tmr_q + CNT_W'(1) : '0;
    else if (state_q == S_READY)
      tmr_d = '0;
    else
      tmr_d = tmr_q + CNT_W'(1);

    // outputs decode the next state so they switch on the same edge as state_q
    pwdn_d      = (state_d == S_WAIT_LOCK) || (state_d == S_PWDN);
    rst_n_d     = (state_d == S_SETTLE) || (state_d == S_CFG) || (state_d == S_READY);
    sys_rst_n_d = (state_d == S_CFG) || (state_d == S_READY);
    cfg_start_d = (state_d == S_CFG) && (state_q != S_CFG);
    ready_d     = (state_d == S_READY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_WAIT_LOCK;
      tmr_q       <= '0;
      retry_q     <= '0;
      pwdn_q      <= 1'b1;
      rst_n_q     <= 1'b0;
      sys_rst_n_q <= 1'b0;
      cfg_start_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      retry_q     <= retry_d;
      pwdn_q      <= pwdn_d;
      rst_n_q     <= rst_n_d;
      sys_rst_n_q <= sys_rst_n_d;
      cfg_start_q <= cfg_start_d;
      ready_q     <= ready_d;
    end
  end

  assign cmos_pwdn  = pwdn_q;
  assign cmos_rst_n = rst_n_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign cfg_start  = cfg_start_q;
  assign ready      = ready_q;
  assign retry_cnt  = retry_q;
  assign state      = state_q;
endmodule

// File: tb/tb_cam_pwr_seq.sv
// Directed bench for cam_pwr_seq with shortened sequence timings.
module tb_cam_pwr_seq;
  logic       clk, reset, locked, cfg_done;
  logic       cmos_pwdn, cmos_rst_n, sys_rst_n, cfg_start, ready;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       pwdn;
    logic       rst_n;
    logic       sys;
    logic       start;
    logic       rdy;
    logic [3:0] retry;
  } exp_t;

  typedef struct {
    logic rst;
    logic lck;
    logic done;
    int   n;
    exp_t e;
  } vec_t;

  cam_pwr_seq #(
    .LOCK_STABLE_CYC (8),
    .PWDN_CYC        (4),
    .RST_CYC         (4),
    .SETTLE_CYC      (6),
    .CFG_TIMEOUT_CYC (20),
    .CNT_W           (24)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .locked     (locked),
    .cfg_done   (cfg_done),
    .cmos_pwdn  (cmos_pwdn),
    .cmos_rst_n (cmos_rst_n),
    .sys_rst_n  (sys_rst_n),
    .cfg_start  (cfg_start),
    .ready      (ready),
    .retry_cnt  (retry_cnt),
    .state      (state)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  function automatic exp_t mk(input int st, input logic p, input logic rn, input logic s,
                              input logic c, input logic rd, input int rt);
    exp_t e;
    e.st = 3'(st); e.pwdn = p; e.rst_n = rn; e.sys = s; e.start = c; e.rdy = rd;
    e.retry = 4'(rt);
    return e;
  endfunction

  // Drive inputs, advance n edges, then sample 1 time unit after the last edge.
  task automatic run(input logic r, input logic l, input logic d, input int n,
                     input exp_t e, input string nm);
    exp_t act;
    reset = r; locked = l; cfg_done = d;
    repeat (n) @(posedge clk);
    #1;
    act = {state, cmos_pwdn, cmos_rst_n, sys_rst_n, cfg_start, ready, retry_cnt};
    tests++;
    if (act !== e) begin
      failed++;
      $display("FAIL %s: got st=%0d pwdn=%b rst_n=%b sys=%b start=%b rdy=%b retry=%0d, want st=%0d pwdn=%b rst_n=%b sys=%b start=%b rdy=%b retry=%0d",
               nm, act.st, act.pwdn, act.rst_n, act.sys, act.start, act.rdy, act.retry,
               e.st, e.pwdn, e.rst_n, e.sys, e.start, e.rdy, e.retry);
    end
  endtask

  vec_t nom[12];

  initial begin
    reset = 1'b1; locked = 1'b0; cfg_done = 1'b0;

    // Nominal sequence, timings counted in edges from the locked rise.
    nom[0]  = '{1'b1, 1'b0, 1'b0,  2, mk(0, 1, 0, 0, 0, 0, 0)};
    nom[1]  = '{1'b0, 1'b1, 1'b0, 13, mk(1, 1, 0, 0, 0, 0, 0)};
    nom[2]  = '{1'b0, 1'b1, 1'b0,  1, mk(2, 0, 0, 0, 0, 0, 0)};
    nom[3]  = '{1'b0, 1'b1, 1'b0,  3, mk(2, 0, 0, 0, 0, 0, 0)};
    nom[4]  = '{1'b0, 1'b1, 1'b0,  1, mk(3, 0, 1, 0, 0, 0, 0)};
    nom[5]  = '{1'b0, 1'b1, 1'b0,  5, mk(3, 0, 1, 0, 0, 0, 0)};
    nom[6]  = '{1'b0, 1'b1, 1'b0,  1, mk(4, 0, 1, 1, 1, 0, 0)};
    nom[7]  = '{1'b0, 1'b1, 1'b0,  1, mk(4, 0, 1, 1, 0, 0, 0)};
    nom[8]  = '{1'b0, 1'b1, 1'b0,  2, mk(4, 0, 1, 1, 0, 0, 0)};
    nom[9]  = '{1'b0, 1'b1, 1'b1,  1, mk(5, 0, 1, 1, 0, 1, 0)};
    nom[10] = '{1'b0, 1'b0, 1'b0,  2, mk(5, 0, 1, 1, 0, 1, 0)};
    nom[11] = '{1'b0, 1'b0, 1'b0,  1, mk(0, 1, 0, 0, 0, 0, 0)};
    foreach (nom[i])
      run(nom[i].rst, nom[i].lck, nom[i].done, nom[i].n, nom[i].e, $sformatf("nom[%0d]", i));

    // Glitchy lock: stable count restarts after the one-cycle drop.
    run(0, 1, 0, 5, mk(0, 1, 0, 0, 0, 0, 0), "glitch_pre");
    run(0, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 0), "glitch_low");
    run(0, 1, 0, 9, mk(0, 1, 0, 0, 0, 0, 0), "glitch_hold");
    run(0, 1, 0, 1, mk(1, 1, 0, 0, 0, 0, 0), "glitch_exit");

    // Timeout with a stale cfg_done in the pulse cycle.
    run(0, 1, 0, 4,  mk(2, 0, 0, 0, 0, 0, 0), "to_rst");
    run(0, 1, 0, 4,  mk(3, 0, 1, 0, 0, 0, 0), "to_settle");
    run(0, 1, 0, 6,  mk(4, 0, 1, 1, 1, 0, 0), "to_cfg");
    run(0, 1, 1, 1,  mk(4, 0, 1, 1, 0, 0, 0), "pulse_done_ignored");
    run(0, 1, 0, 18, mk(4, 0, 1, 1, 0, 0, 0), "to_last_cycle");
    run(0, 1, 0, 1,  mk(1, 1, 0, 0, 0, 0, 1), "timeout");

    // cfg_done and timeout in the same cycle: done wins.
    run(0, 1, 0, 14, mk(4, 0, 1, 1, 1, 0, 1), "sim_cfg");
    run(0, 1, 0, 19, mk(4, 0, 1, 1, 0, 0, 1), "sim_tmr19");
    run(0, 1, 1, 1,  mk(5, 0, 1, 1, 0, 1, 1), "sim_done_wins");

    // Lock loss from READY keeps retry_cnt.
    run(0, 0, 0, 3, mk(0, 1, 0, 0, 0, 0, 1), "lock_loss");
    run(0, 1, 0, 9, mk(0, 1, 0, 0, 0, 0, 1), "relock_wait");
    run(0, 1, 0, 1, mk(1, 1, 0, 0, 0, 0, 1), "relock_pwdn");

    // Repeated timeouts saturate retry_cnt.
    for (int i = 2; i <= 17; i++)
      run(0, 1, 0, 34, mk(1, 1, 0, 0, 0, 0, (i > 15) ? 15 : i), $sformatf("retry_%0d", i));

    // Reset during SETTLE, then a full restart from the lock-stable count.
    run(0, 1, 0, 8, mk(3, 0, 1, 0, 0, 0, 15), "pre_reset_settle");
    run(1, 1, 0, 1, mk(0, 1, 0, 0, 0, 0, 0),  "mid_reset");
    run(0, 1, 0, 9, mk(0, 1, 0, 0, 0, 0, 0),  "post_reset_wait");
    run(0, 1, 0, 1, mk(1, 1, 0, 0, 0, 0, 0),  "post_reset_pwdn");
    run(0, 1, 0, 4, mk(2, 0, 0, 0, 0, 0, 0),  "post_reset_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
